// File: rtl/psum_acc_12.sv
// psum_acc_12 -- partial-sum accumulator behind the 12-bit pipelined add stage.
//
// A job is started with start_i. It then takes len_i signed DATA_W-bit terms
// (len_i == 0 counts as one term) and adds them into an ACC_W-bit accumulator.
// The total is saturated back to DATA_W bits, optionally passed through a ReLU
// (relu_en_i is latched with start_i), and offered to the next layer buffer.
//
// Handshakes: a transfer happens on a rising clk_i edge where both valid and
// ready are high (valid_i & ready_o on the input side, result_valid_o &
// result_ready_i on the output side). A source holds its valid and payload
// stable until that transfer. ready_o does not depend on valid_i.
//
// Optional build macro PSUM_ROUND_EN: round the total half-up to a multiple of
// 16 before clamping. The clamp range is then [-2048, 2032].
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous reset, active high
//   start_i        start a job (sampled only while idle)
//   len_i          number of terms in the job (0 counts as 1)
//   relu_en_i      ReLU enable for the job, latched with start_i
//   data_i         partial-sum term
//   valid_i        data_i valid
//   ready_o        term accepted on this cycle's edge when valid_i is high
//   result_o       saturated, optionally ReLU'd result
//   result_valid_o result_o valid
//   result_ready_i consumer takes the result
//   ovf_o          result was clamped (qualified by result_valid_o)
//   busy_o         job in progress (not idle)
module psum_acc_12 #(
    parameter int DATA_W = 12,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = 20   // must be >= DATA_W + LEN_W so the sum never wraps
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              relu_en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic              ovf_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_SAT   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         cnt_q;
    logic                     relu_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [DATA_W-1:0]        result_q;
    logic                     ovf_q;
    logic                     rvalid_q;

    logic                     beat_ok;
    logic                     last_beat;
    logic signed [ACC_W-1:0]  data_ext;

    // Saturation path.
    logic signed [ACC_W-1:0]  pre_sat;
    logic [DATA_W-1:0]        sat_val;
    logic [DATA_W-1:0]        sat_res;
    logic                     sat_ovf;

    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));
`ifdef PSUM_ROUND_EN
    // Largest multiple of 16 that still fits in DATA_W bits.
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 16);
    // Half-up rounding to the 16-step grid: add half a step, drop the low nibble.
    assign pre_sat = (acc_q + ACC_W'(8)) & ~ACC_W'(15);
`else
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    assign pre_sat = acc_q;
`endif

    assign data_ext  = {{(ACC_W - DATA_W){data_i[DATA_W-1]}}, data_i};
    assign beat_ok   = (state_q == S_ACCUM) && valid_i;
    assign last_beat = beat_ok && (cnt_q == (len_q - LEN_W'(1)));

    // ReLU is applied after the clamp and never touches the overflow flag.
    always_comb begin
        sat_ovf = 1'b0;
        sat_val = pre_sat[DATA_W-1:0];
        if (pre_sat > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_W-1:0];
            sat_ovf = 1'b1;
        end else if (pre_sat < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_W-1:0];
            sat_ovf = 1'b1;
        end
        sat_res = (relu_q && sat_val[DATA_W-1]) ? '0 : sat_val;
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        busy_o  = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                ready_o = 1'b1;
                if (last_beat) begin
                    state_d = S_SAT;
                end
            end
            S_SAT: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                if (result_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q    <= '0;
            cnt_q    <= '0;
            relu_q   <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        len_q  <= (len_i == '0) ? LEN_W'(1) : len_i;
                        relu_q <= relu_en_i;
                        acc_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                S_ACCUM: begin
                    if (beat_ok) begin
                        acc_q <= acc_q + data_ext;
                        cnt_q <= cnt_q + LEN_W'(1);
                    end
                end
                S_SAT: begin
                    result_q <= sat_res;
                    ovf_q    <= sat_ovf;
                    rvalid_q <= 1'b1;
                end
                S_OUT: begin
                    if (result_ready_i) begin
                        rvalid_q <= 1'b0;
                    end
                end
                default: begin
                    rvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign result_o       = result_q;
    assign ovf_o          = ovf_q;
    assign result_valid_o = rvalid_q;

endmodule

// File: tb/tb_psum_acc_12.sv
`timescale 1ns/1ps
module tb_psum_acc_12;

    localparam int DATA_W = 12;
    localparam int LEN_W  = 8;
    localparam int ACC_W  = 20;

    // ---------------- clock / reset / DUT ----------------
    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic [LEN_W-1:0]  len_i = '0;
    logic              relu_en_i = 1'b0;
    logic [DATA_W-1:0] data_i = '0;
    logic              valid_i = 1'b0;
    logic              result_ready_i = 1'b0;
    logic              ready_o;
    logic [DATA_W-1:0] result_o;
    logic              result_valid_o;
    logic              ovf_o;
    logic              busy_o;

    psum_acc_12 #(.DATA_W(DATA_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .len_i          (len_i),
        .relu_en_i      (relu_en_i),
        .data_i         (data_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .ovf_o          (ovf_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_line(input string name);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    // Result of a job from the plain integer sum of its accepted terms.
    function automatic logic [DATA_W:0] ref_out(input int sum, input bit relu);
        int v;
        int hi;
        bit ov;
`ifdef PSUM_ROUND_EN
        v  = ((sum + 8) >>> 4) * 16;
        hi = 2032;
`else
        v  = sum;
        hi = 2047;
`endif
        ov = (v > hi) || (v < -2048);
        if (v > hi) v = hi;
        if (v < -2048) v = -2048;
        if (relu && v < 0) v = 0;
        return {ov, v[DATA_W-1:0]};
    endfunction

    // Job phase: 0 idle, 1 taking terms, 2 saturating, 3 result offered.
    int m_ph = 0;
    int m_len = 1;
    int m_cnt = 0;
    int m_sum = 0;
    bit m_relu = 1'b0;
    bit m_rv = 1'b0;
    logic [DATA_W:0] exp_q[$];

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_ph = 0;
            m_cnt = 0;
            m_sum = 0;
            m_rv = 1'b0;
            exp_q.delete();
        end else begin
            case (m_ph)
                0: if (start_i) begin
                    m_len  = (len_i == 0) ? 1 : int'(len_i);
                    m_relu = relu_en_i;
                    m_sum  = 0;
                    m_cnt  = 0;
                    m_ph   = 1;
                end
                1: if (valid_i) begin
                    m_sum += int'($signed(data_i));
                    m_cnt++;
                    if (m_cnt == m_len) m_ph = 2;
                end
                2: begin
                    exp_q.push_back(ref_out(m_sum, m_relu));
                    m_rv = 1'b1;
                    m_ph = 3;
                end
                default: if (result_ready_i) begin
                    m_rv = 1'b0;
                    m_ph = 0;
                end
            endcase
        end
    end

    // ---------------- compare process ----------------
    int rv_rise_cyc = 0;
    int last_beat_cyc = 0;
    bit prev_rv = 1'b0;
    logic [DATA_W:0] head;

    always @(negedge clk_i) begin
        check("ready_o", ready_o, m_ph == 1);
        check("busy_o", busy_o, m_ph != 0);
        check("result_valid_o", result_valid_o, m_rv);
        if (result_valid_o && m_rv) begin
            if (exp_q.size() == 0) begin
                fail_line("scoreboard_empty");
            end else begin
                head = exp_q[0];
                check("result_o", result_o, head[DATA_W-1:0]);
                check("ovf_o", ovf_o, head[DATA_W]);
                if (result_ready_i) void'(exp_q.pop_front());
            end
        end
        if (result_valid_o && !prev_rv) rv_rise_cyc = cyc;
        prev_rv = result_valid_o;
    end

    // ---------------- driver ----------------
    logic [DATA_W-1:0] beats [0:255];
    logic [DATA_W-1:0] got_res;
    logic              got_ovf;

    // Called just after a rising edge with the DUT idle. Returns just after
    // the edge that completes the result handshake.
    task automatic run_job(input int len, input bit relu, input int stall,
                           input bit gaps, input bit poke);
        int n;
        int i;
        int guard;
        n = (len == 0) ? 1 : len;
        start_i   = 1'b1;
        len_i     = LEN_W'(len);
        relu_en_i = relu;
        @(posedge clk_i); #1;
        start_i   = 1'b0;
        len_i     = LEN_W'($urandom);
        relu_en_i = 1'($urandom_range(0, 1));
        i = 0;
        guard = 0;
        while (i < n && guard < 4000) begin
            start_i = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            if (gaps && $urandom_range(0, 2) == 0) begin
                valid_i = 1'b0;
                data_i  = DATA_W'($urandom);
            end else begin
                valid_i = 1'b1;
                data_i  = beats[i];
                last_beat_cyc = cyc;
                i++;
            end
            @(posedge clk_i); #1;
            guard++;
        end
        start_i = 1'b0;
        // Junk terms offered while the result is pending must be left alone.
        valid_i = 1'b1;
        data_i  = DATA_W'($urandom);
        guard = 0;
        while (!result_valid_o && guard < 8) begin
            @(posedge clk_i); #1;
            guard++;
        end
        if (!result_valid_o) begin
            fail_line("timeout_result_valid");
        end else begin
            repeat (stall) begin
                data_i = DATA_W'($urandom);
                @(posedge clk_i); #1;
            end
            got_res = result_o;
            got_ovf = ovf_o;
            result_ready_i = 1'b1;
            @(posedge clk_i); #1;
            result_ready_i = 1'b0;
        end
        valid_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rlen;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_result", result_o, 0);
        check("reset_rvalid", result_valid_o, 0);
        check("reset_ovf", ovf_o, 0);
        check("reset_ready", ready_o, 0);
        check("reset_busy", busy_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Basic sum with latency.
        beats[0] = 12'h100; beats[1] = 12'h200; beats[2] = 12'h010; beats[3] = 12'hFF0;
        run_job(4, 1'b0, 0, 1'b0, 1'b0);
        check("basic_result", got_res, 12'h300);
        check("basic_ovf", got_ovf, 0);
        check("basic_latency", rv_rise_cyc - last_beat_cyc, 2);

        // Positive saturation.
        beats[0] = 12'h7F0; beats[1] = 12'h7F0; beats[2] = 12'h7F0;
        run_job(3, 1'b0, 0, 1'b0, 1'b0);
`ifdef PSUM_ROUND_EN
        check("possat_result", got_res, 12'h7F0);
`else
        check("possat_result", got_res, 12'h7FF);
`endif
        check("possat_ovf", got_ovf, 1);

        // ReLU on and off; start a new job right after each handshake.
        beats[0] = 12'hF00; beats[1] = 12'hF00;
        run_job(2, 1'b1, 0, 1'b0, 1'b0);
        check("relu_on_result", got_res, 12'h000);
        check("relu_on_ovf", got_ovf, 0);
        run_job(2, 1'b0, 0, 1'b0, 1'b0);
        check("relu_off_result", got_res, 12'hE00);
        check("relu_off_ovf", got_ovf, 0);

        // Gaps on the input, 5-cycle stall on the output.
        beats[0] = 12'h010; beats[1] = 12'h020; beats[2] = 12'h030;
        run_job(3, 1'b0, 5, 1'b1, 1'b0);
        check("gaps_result", got_res, 12'h060);
        check("busy_after_handshake", busy_o, 0);

        // start_i pulsed while taking terms (including the last term).
        beats[0] = 12'h001; beats[1] = 12'h002; beats[2] = 12'h003; beats[3] = 12'h004;
        run_job(4, 1'b0, 1, 1'b0, 1'b1);
`ifdef PSUM_ROUND_EN
        check("poke_result", got_res, 12'h010);
`else
        check("poke_result", got_res, 12'h00A);
`endif

        // len = 0 takes exactly one term.
        beats[0] = 12'h123;
        run_job(0, 1'b0, 0, 1'b0, 1'b0);
`ifdef PSUM_ROUND_EN
        check("len0_result", got_res, 12'h120);
`else
        check("len0_result", got_res, 12'h123);
`endif

        // Reset after 2 of 4 terms.
        start_i = 1'b1; len_i = 8'd4; relu_en_i = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        valid_i = 1'b1; data_i = 12'h111;
        @(posedge clk_i); #1;
        data_i = 12'h222;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check("midrst_result", result_o, 0);
        check("midrst_rvalid", result_valid_o, 0);
        check("midrst_ovf", ovf_o, 0);
        check("midrst_ready", ready_o, 0);
        check("midrst_busy", busy_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;
        beats[0] = 12'h050;
        run_job(1, 1'b0, 0, 1'b0, 1'b0);
        check("postrst_result", got_res, 12'h050);

        // Longest job, most negative terms.
        for (int k = 0; k < 255; k++) beats[k] = 12'h800;
        run_job(255, 1'b0, 0, 1'b0, 1'b0);
        check("negsat_result", got_res, 12'h800);
        check("negsat_ovf", got_ovf, 1);

        // Random jobs against the model.
        for (int j = 0; j < 30; j++) begin
            rlen = $urandom_range(0, 24);
            for (int k = 0; k < 256; k++) begin
                if (j % 3 == 0) beats[k] = DATA_W'($urandom_range(0, 255)) + 12'h700;
                else beats[k] = DATA_W'($urandom);
            end
            run_job(rlen, 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                    1'b1, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            #1;
        end

        repeat (3) @(posedge clk_i);
        #1;
        if (exp_q.size() != 0) fail_line("scoreboard_leftover");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        fail_line("global_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "global timeout");
    end

endmodule
